// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative radix-2 multiply/divide unit for the execute stage.
//
// Ports
//   clock      system clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle request strobe, sampled only while busy is low
//   op         000 MUL, 001 MULH, 010 MULHU, 011 reserved,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   operand_a  multiplicand / dividend, captured on the accepting edge
//   operand_b  multiplier / divisor, captured on the accepting edge
//   result     result word, held from one ready pulse until the next
//   exception  error flag belonging to result, held like result
//   ready      one-cycle completion pulse
//   busy       high while an operation is in flight
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one shift-add / shift-subtract step per cycle, WIDTH steps
// FIX   | remainder restore, sign correction, output selection
// DONE  | ready pulse; a new start may be accepted in this cycle
// ZERO  | divide-by-zero or reserved op; result forced, exception set

module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             ready,
   output logic             busy
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RUN  = 3'd1;
   localparam logic [2:0] ST_FIX  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ZERO = 3'd4;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MULH  = 3'b001;
   localparam logic [2:0] OP_MULHU = 3'b010;
   localparam logic [2:0] OP_RSVD  = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;
   localparam logic [2:0] OP_REM   = 3'b110;
   localparam logic [2:0] OP_REMU  = 3'b111;

   logic [2:0]       state, state_nx;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             neg_a, neg_b;
   // work_hi: partial product high half (multiply) or signed partial
   // remainder with two guard bits (divide). work_lo: multiplier being
   // shifted out (multiply) or dividend/quotient shift register (divide).
   logic [WIDTH+1:0] work_hi;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] opb_mag;

   logic             signed_in, neg_a_in, neg_b_in, zero_in, accept;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_sh, div_d, div_nx;

   logic [2*WIDTH-1:0] prod_mag, prod_s;
   logic [WIDTH-1:0]   rem_mag, rem_s, quot_s;
   logic               mul_ovf, div_ovf;
   logic [WIDTH-1:0]   fix_result, zero_result;

   assign busy  = (state == ST_RUN) || (state == ST_FIX) || (state == ST_ZERO);
   assign ready = (state == ST_DONE);

   // MUL is treated as signed so its overflow flag reflects the signed product.
   assign signed_in = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign neg_a_in  = signed_in && operand_a[WIDTH-1];
   assign neg_b_in  = signed_in && operand_b[WIDTH-1];
   assign a_mag_in  = neg_a_in ? -operand_a : operand_a;
   assign b_mag_in  = neg_b_in ? -operand_b : operand_b;
   assign zero_in   = (op == OP_RSVD) || (op[2] && (operand_b == '0));
   assign accept    = start && !busy;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ZERO: begin
            if (state == ST_ZERO)
               state_nx = ST_DONE;
            else if (accept)
               state_nx = zero_in ? ST_ZERO : ST_RUN;
            else
               state_nx = ST_IDLE;
         end
         ST_RUN:  if (cnt == CNT_W'(1)) state_nx = ST_FIX;
         ST_FIX:  state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // One radix-2 step. Non-restoring divide keeps the partial remainder
   // signed and picks add or subtract from its sign.
   assign mul_sum = {1'b0, work_hi[WIDTH-1:0]} + (work_lo[0] ? {1'b0, opb_mag} : '0);
   assign div_sh  = {work_hi[WIDTH:0], work_lo[WIDTH-1]};
   assign div_d   = {2'b00, opb_mag};
   assign div_nx  = work_hi[WIDTH+1] ? (div_sh + div_d) : (div_sh - div_d);

   always_ff @(posedge clock) begin
      if (accept) begin
         op_q    <= op;
         neg_a   <= neg_a_in;
         neg_b   <= neg_b_in;
         cnt     <= CNT_W'(WIDTH);
         work_hi <= '0;
         // The zero path returns the raw dividend for REM/REMU.
         work_lo <= zero_in ? operand_a : a_mag_in;
         opb_mag <= b_mag_in;
      end else if (state == ST_RUN) begin
         cnt <= cnt - CNT_W'(1);
         if (op_q[2]) begin
            work_hi <= div_nx;
            work_lo <= {work_lo[WIDTH-2:0], ~div_nx[WIDTH+1]};
         end else begin
            work_hi <= {2'b00, mul_sum[WIDTH:1]};
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
         end
      end
   end

   always_comb begin
      prod_mag = {work_hi[WIDTH-1:0], work_lo};
      prod_s   = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
      // Final remainder is in [0, divisor) so WIDTH-bit wraparound is exact.
      rem_mag  = work_hi[WIDTH+1] ? (work_hi[WIDTH-1:0] + opb_mag) : work_hi[WIDTH-1:0];
      quot_s   = (neg_a ^ neg_b) ? -work_lo : work_lo;
      rem_s    = neg_a ? -rem_mag : rem_mag;
      mul_ovf  = (op_q == OP_MUL) && (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      // A positive signed quotient with its MSB set can only come from MIN / -1.
      div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) && !(neg_a ^ neg_b) && work_lo[WIDTH-1];

      fix_result = '0;
      case (op_q)
         OP_MUL:                  fix_result = prod_s[WIDTH-1:0];
         OP_MULH, OP_MULHU:       fix_result = prod_s[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:         fix_result = quot_s;
         OP_REM, OP_REMU:         fix_result = div_ovf ? '0 : rem_s;
         default:                 fix_result = '0;
      endcase

      zero_result = '0;
      case (op_q)
         OP_DIV, OP_DIVU: zero_result = '1;
         OP_REM, OP_REMU: zero_result = work_lo;
         default:         zero_result = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_FIX) begin
            result    <= fix_result;
            exception <= mul_ovf || div_ovf;
         end else if (state == ST_ZERO) begin
            result    <= zero_result;
            exception <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MULH  = 3'b001;
   localparam logic [2:0] OP_MULHU = 3'b010;
   localparam logic [2:0] OP_RSVD  = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;
   localparam logic [2:0] OP_REM   = 3'b110;
   localparam logic [2:0] OP_REMU  = 3'b111;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        start32, start8;
   logic [2:0]  op32, op8;
   logic [31:0] a32, b32, result32;
   logic [7:0]  a8, b8, result8;
   logic        exc32, exc8, ready32, ready8, busy32, busy8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   multdiv_unit #(.WIDTH(32)) dut32 (
      .clock(clock), .rst_n(rst_n), .start(start32), .op(op32),
      .operand_a(a32), .operand_b(b32), .result(result32),
      .exception(exc32), .ready(ready32), .busy(busy32)
   );

   multdiv_unit #(.WIDTH(8)) dut8 (
      .clock(clock), .rst_n(rst_n), .start(start8), .op(op8),
      .operand_a(a8), .operand_b(b8), .result(result8),
      .exception(exc8), .ready(ready8), .busy(busy8)
   );

   typedef struct {
      bit          sel8;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic get_ready(input bit sel8);
      return sel8 ? ready8 : ready32;
   endfunction
   function automatic logic get_busy(input bit sel8);
      return sel8 ? busy8 : busy32;
   endfunction
   function automatic logic get_exc(input bit sel8);
      return sel8 ? exc8 : exc32;
   endfunction
   function automatic logic [31:0] get_result(input bit sel8);
      return sel8 ? {24'd0, result8} : result32;
   endfunction

   // Reference model: plain integer arithmetic on the operands as numbers.
   task automatic model(input int w, input logic [2:0] op_v, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic exc,
                        output int lat);
      longint      mask, sa, sb, minv, p, q;
      logic [63:0] ua, ub, pu;
      mask = (longint'(1) << w) - 1;
      ua   = {32'd0, a} & 64'(mask);
      ub   = {32'd0, b} & 64'(mask);
      sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
      sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
      minv = -(longint'(1) << (w - 1));
      p    = sa * sb;
      pu   = ua * ub;
      exc  = 1'b0;
      res  = '0;
      case (op_v)
         OP_MUL: begin
            res = 32'(p & mask);
            exc = (p < minv) || (p > -minv - 1);
         end
         OP_MULH:  res = 32'((p >>> w) & mask);
         OP_MULHU: res = 32'((pu >> w) & 64'(mask));
         OP_DIV, OP_REM: begin
            if (ub == 0) begin
               res = (op_v == OP_DIV) ? 32'(mask) : 32'(ua);
               exc = 1'b1;
            end else if (sa == minv && sb == -1) begin
               res = (op_v == OP_DIV) ? 32'(ua) : 32'd0;
               exc = 1'b1;
            end else begin
               q   = (op_v == OP_DIV) ? (sa / sb) : (sa % sb);
               res = 32'(q & mask);
            end
         end
         OP_DIVU, OP_REMU: begin
            if (ub == 0) begin
               res = (op_v == OP_DIVU) ? 32'(mask) : 32'(ua);
               exc = 1'b1;
            end else begin
               res = (op_v == OP_DIVU) ? 32'(ua / ub) : 32'(ua % ub);
            end
         end
         default: begin
            res = '0;
            exc = 1'b1;
         end
      endcase
      lat = ((op_v == OP_RSVD) || (op_v[2] && ub == 0)) ? 2 : w + 2;
   endtask

   task automatic drive_start(input bit sel8, input logic [2:0] op_v,
                              input logic [31:0] a, input logic [31:0] b);
      if (sel8) begin
         start8 = 1'b1; op8 = op_v; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         start32 = 1'b1; op32 = op_v; a32 = a; b32 = b;
      end
   endtask

   // Scramble inputs after the accepting edge; they must have no effect.
   task automatic drop_start;
      start8  = 1'b0;
      start32 = 1'b0;
      op8     = 3'($urandom);
      op32    = 3'($urandom);
      a8      = 8'($urandom);
      b8      = 8'($urandom);
      a32     = $urandom;
      b32     = $urandom;
   endtask

   task automatic wait_ready(input bit sel8, input string name, output int lat, output int busy_cnt);
      lat      = 1;
      busy_cnt = 0;
      while (!get_ready(sel8) && lat < 100) begin
         if (get_busy(sel8)) busy_cnt++;
         @(negedge clock);
         lat++;
      end
      check({name, "_ready_seen"}, get_ready(sel8), 1'b1);
   endtask

   task automatic do_op(input bit sel8, input logic [2:0] op_v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_exc, input int exp_lat, input string name);
      int lat, bc;
      @(negedge clock);
      check({name, "_no_double_ready"}, get_ready(sel8), 1'b0);
      drive_start(sel8, op_v, a, b);
      @(negedge clock);
      drop_start();
      wait_ready(sel8, name, lat, bc);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_busy_cycles"}, bc, exp_lat - 1);
      check({name, "_busy_at_ready"}, get_busy(sel8), 1'b0);
      check({name, "_result"}, get_result(sel8), exp_res);
      check({name, "_exception"}, get_exc(sel8), exp_exc);
   endtask

   function automatic logic [31:0] pick(input int w);
      logic [31:0] mask;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return mask;
         3:       return 32'd1 << (w - 1);
         default: return $urandom & mask;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, extra;
      logic [31:0] er;
      logic        ee;
      int          el;

      rst_n = 1'b0;
      start32 = 1'b0; start8 = 1'b0;
      op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_result32", result32, 32'd0);
      check("reset_exc32", exc32, 1'b0);
      check("reset_ready32", ready32, 1'b0);
      check("reset_busy32", busy32, 1'b0);
      check("reset_result8", {24'd0, result8}, 32'd0);
      check("reset_busy8", busy8, 1'b0);
      rst_n = 1'b1;

      vecs.push_back('{0, OP_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34});
      vecs.push_back('{0, OP_MUL,   32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 34});
      vecs.push_back('{0, OP_MULHU, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 1'b0, 34});
      vecs.push_back('{0, OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34});
      vecs.push_back('{0, OP_MUL,   32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 34});
      vecs.push_back('{0, OP_MUL,   32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 34});
      vecs.push_back('{0, OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 34});
      vecs.push_back('{0, OP_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 34});
      vecs.push_back('{0, OP_DIVU,  32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0, 34});
      vecs.push_back('{0, OP_REMU,  32'hFFFF_FFF9,  32'd2,         32'h0000_0001, 1'b0, 34});
      vecs.push_back('{0, OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34});
      vecs.push_back('{0, OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 34});
      vecs.push_back('{0, OP_DIVU,  32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 2});
      vecs.push_back('{0, OP_REM,   32'd5,          32'd0,         32'h0000_0005, 1'b1, 2});
      vecs.push_back('{0, OP_RSVD,  32'd9,          32'd3,         32'h0000_0000, 1'b1, 2});
      vecs.push_back('{1, OP_MULHU, 32'hFF,         32'hFF,        32'h0000_00FE, 1'b0, 10});
      vecs.push_back('{1, OP_DIV,   32'h80,         32'hFF,        32'h0000_0080, 1'b1, 10});
      vecs.push_back('{1, OP_MUL,   32'h10,         32'h08,        32'h0000_0080, 1'b1, 10});

      for (int i = 0; i < vecs.size(); i++)
         do_op(vecs[i].sel8, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
               vecs[i].exc, vecs[i].lat, $sformatf("vec%0d", i));

      // start while busy is ignored; first result stands
      @(negedge clock);
      drive_start(0, OP_MUL, 32'd7, 32'hFFFF_FFFD);
      @(negedge clock);
      drop_start();
      lat = 1;
      repeat (4) begin @(negedge clock); lat++; end
      drive_start(0, OP_MUL, 32'd100, 32'd100);
      @(negedge clock);
      lat++;
      drop_start();
      while (!ready32 && lat < 100) begin @(negedge clock); lat++; end
      check("ignore_latency", lat, 34);
      check("ignore_result", result32, 32'hFFFF_FFEB);
      extra = 0;
      repeat (40) begin @(negedge clock); if (ready32) extra++; end
      check("ignore_no_extra_ready", extra, 0);

      // back-to-back: start in the ready cycle
      @(negedge clock);
      drive_start(0, OP_DIVU, 32'd100, 32'd7);
      @(negedge clock);
      drop_start();
      wait_ready(0, "b2b_first", lat, bc);
      check("b2b_first_result", result32, 32'd14);
      drive_start(0, OP_REMU, 32'd100, 32'd7);
      @(negedge clock);
      drop_start();
      check("b2b_ready_gap", ready32, 1'b0);
      check("b2b_accepted_busy", busy32, 1'b1);
      check("b2b_result_held", result32, 32'd14);
      wait_ready(0, "b2b_second", lat, bc);
      check("b2b_second_latency", lat, 34);
      check("b2b_second_result", result32, 32'd2);

      // reset mid-RUN: outputs cleared, no ready pulse
      do_op(0, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, "pre_reset");
      @(negedge clock);
      drive_start(0, OP_MUL, 32'd5, 32'd5);
      @(negedge clock);
      drop_start();
      repeat (10) @(negedge clock);
      check("rst_busy_before", busy32, 1'b1);
      rst_n = 1'b0;
      @(negedge clock);
      check("rst_result", result32, 32'd0);
      check("rst_exception", exc32, 1'b0);
      check("rst_ready", ready32, 1'b0);
      check("rst_busy", busy32, 1'b0);
      rst_n = 1'b1;
      extra = 0;
      repeat (45) begin @(negedge clock); if (ready32) extra++; end
      check("rst_no_ready", extra, 0);

      // randomized operations against the reference model
      for (int i = 0; i < 80; i++) begin
         bit          s8;
         int          w;
         logic [2:0]  op_v;
         logic [31:0] a, b;
         s8   = (i % 2) == 1;
         w    = s8 ? 8 : 32;
         op_v = 3'($urandom_range(0, 7));
         a    = pick(w);
         b    = pick(w);
         model(w, op_v, a, b, er, ee, el);
         do_op(s8, op_v, a, b, er, ee, el,
               $sformatf("rand%0d_w%0d_op%0d_a%0h_b%0h", i, w, op_v, a, b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised iterative multiply/divide unit that replaces the fixed 32-bit mult/div pair in the processor's execute stage. It supports signed and unsigned multiply (low and high halves), divide and remainder at a configurable `WIDTH`. Control is a single `start` strobe with an opcode, and results come back through a `ready`/`busy` handshake. Divide-by-zero completes early; signed overflow is flagged.

## Interface
- `WIDTH`, 32: operand/result width in bits (>= 4).
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

- `clock`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request strobe; sampled only when `busy`=0.
- `op`  in  3  000 MUL, 001 MULH (s×s), 010 MULHU (u×u), 011 reserved, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  WIDTH  multiplicand / dividend; captured on the accepting edge.
- `operand_b`  in  WIDTH  multiplier / divisor; captured on the accepting edge.
- `result`  out  WIDTH  result; held from `ready` until the next `ready`.
- `exception`  out  1  error flag for the current `result`; held like `result`.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States: IDLE, RUN, FIX, DONE, ZERO.
- **IDLE / DONE, `start`=1:**
  - Capture operands and `op`, convert to magnitudes (signed ops), record result sign.
  - Load counter = WIDTH.
  - Go to RUN. If a divide/remainder op has `operand_b`=0, go to ZERO instead.
  - `op`=011 also goes to ZERO.
- **RUN:** one radix-2 step per cycle; counter decrements; at 1, go to FIX.
  - Multiply: 2·WIDTH-bit shift-add on magnitudes.
  - Divide: non-restoring shift-subtract on magnitudes.
- **FIX:**
  - Divide: final remainder restore.
  - Signed ops: two's-complement negation where needed.
  - Multiply sign = sign(a)^sign(b). Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
  - Select the output half/word; go to DONE.
- **DONE:** `ready`=1 for this cycle only. Go to IDLE, or RUN/ZERO if `start`=1.
- **ZERO:** takes one cycle, then asserts `ready` with `exception`=1.
  - DIV/DIVU: `result` = all ones.
  - REM/REMU: `result` = `operand_a`.
  - op 011: `result` = 0.
  - Go to IDLE, or accept `start` as DONE does.
- **Result selection:**
  - MUL: low WIDTH bits.
  - MULH/MULHU: high WIDTH bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- **Exception conditions:**
  - MUL: the full signed product is not representable in WIDTH bits signed.
  - DIV/REM with `operand_a`=MIN and `operand_b`=-1: quotient=MIN, remainder=0, `exception`=1.
  - MULH/MULHU/DIVU/REMU: never, except divide-by-zero.
- **Boundaries:**
  - `start` while `busy`=1 is ignored; operands are not re-captured.
  - `rst_n`=0 mid-operation aborts with no `ready`.
  - Input changes after the accepting edge have no effect.

## Timing
- **Reset** (`rst_n` low at an edge):
  - State IDLE.
  - `result`=0, `exception`=0, `ready`=0, `busy`=0.
- **Normal latency:** `start` sampled at edge t.
  - `busy`=1 from t+1 to t+WIDTH+1.
  - `ready`=1 at t+WIDTH+2, with `busy`=0 in that cycle.
  - `result`/`exception` valid from t+WIDTH+2.
  - WIDTH=32: 34 cycles.
- **ZERO latency:** `busy`=1 at t+1, `ready`=1 at t+2.
- **Back-to-back:** `start` in the `ready` cycle is accepted. The next `ready` follows after the same latency, with no idle gap.
- `ready` is never asserted two cycles in a row for a single operation.

## Test plan
- **Signed MUL:** WIDTH=32, MUL a=7, b=-3 → `result`=0xFFFFFFEB, `exception`=0, `ready` exactly 34 cycles after `start`, `busy` high 33 cycles.
- **Overflow and high half:** MUL 0x00010000×0x00010000 → `result`=0, `exception`=1. MULHU same operands → `result`=0x00000001, `exception`=0. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU same → 1. DIV 0x80000000/−1 → 0x80000000 with `exception`=1.
- **Divide-by-zero:** DIVU 5/0 → `result`=0xFFFFFFFF, `exception`=1, `ready` 2 cycles after `start`. REM 5/0 → `result`=5.
- **Parameterisation:** WIDTH=8 instance, MULHU 0xFF×0xFF → `result`=0xFE, `ready` 10 cycles after `start`. DIV 0x80/0xFF → 0x80, `exception`=1.
- **Control boundaries:**
  - Second `start` with different operands while busy → ignored; the first result is unchanged.
  - `start` in the `ready` cycle → accepted; the second `ready` follows 34 cycles later.
  - `rst_n`=0 mid-RUN → all outputs 0 the next cycle; no `ready` pulse.
